// File: rtl/fft_mag_pkg.sv
// Shared types and constants for the iterative CORDIC magnitude estimator.
package fft_mag_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    SCALE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Inverse CORDIC gain 0.60725 in Q16
  localparam logic [15:0] K_Q16 = 16'd39797;

  function automatic int cnt_w(input int iter);
    return (iter < 1) ? 1 : $clog2(iter + 1);
  endfunction
endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring micro-rotation: drives y toward zero, x accumulates magnitude.
module cordic_vec_step #(
  parameter int W  = 18,
  parameter int SW = 4
) (
  input  logic        [W-1:0]  i_x,
  input  logic signed [W-1:0]  i_y,
  input  logic        [SW-1:0] i_sh,
  output logic        [W-1:0]  o_x,
  output logic signed [W-1:0]  o_y
);
  logic        [W-1:0] w_xs;
  logic signed [W-1:0] w_ys;

  // x never goes negative in vectoring mode, so a logical shift equals arithmetic
  assign w_xs = i_x >> i_sh;
  assign w_ys = i_y >>> i_sh;

  always_comb begin
    if (!i_y[W-1]) begin
      o_x = i_x + $unsigned(w_ys);
      o_y = i_y - $signed(w_xs);
    end else begin
      o_x = i_x - $unsigned(w_ys);
      o_y = i_y + $signed(w_xs);
    end
  end
endmodule

// File: rtl/fft_mag_cordic.sv
// Iterative vectoring-CORDIC magnitude of a complex bin, one micro-rotation per clock.
// Define MAG_GAIN_COMP_EN to add a SCALE cycle that removes the CORDIC gain.
module fft_mag_cordic
  import fft_mag_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_mag
);
  localparam int W2 = WIDTH + 2;
  localparam int CW = cnt_w(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  state_t               r_state;
  logic        [W2-1:0] r_x;
  logic signed [W2-1:0] r_y;
  logic        [CW-1:0] r_cnt;
  logic                 r_out_valid;
  logic        [W2-1:0] r_mag;

  logic [WIDTH-1:0]     w_re_abs, w_im_abs;
  logic        [W2-1:0] w_x0, w_x_n;
  logic signed [W2-1:0] w_y0, w_y_n;

  // -2^(WIDTH-1) negates to itself, which reads as +2^(WIDTH-1) unsigned
  assign w_re_abs = in_re[WIDTH-1] ? (~in_re + 1'b1) : in_re;
  assign w_im_abs = in_im[WIDTH-1] ? (~in_im + 1'b1) : in_im;
  assign w_x0     = {2'b00, w_re_abs};
  assign w_y0     = $signed({2'b00, w_im_abs});

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid = r_out_valid;
  assign out_mag   = r_mag;

  cordic_vec_step #(.W(W2), .SW(CW)) u_step (
    .i_x  (r_x),
    .i_y  (r_y),
    .i_sh (r_cnt),
    .o_x  (w_x_n),
    .o_y  (w_y_n)
  );

`ifdef MAG_GAIN_COMP_EN
  logic [W2+15:0] w_prod;
  assign w_prod = {16'b0, r_x} * {{W2{1'b0}}, K_Q16};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_mag       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_cnt   <= '0;
            r_state <= ROTATE;
          end
        end
        ROTATE: begin
          r_x <= w_x_n;
          r_y <= w_y_n;
          if (r_cnt == CNT_LAST) begin
`ifdef MAG_GAIN_COMP_EN
            r_state     <= SCALE;
`else
            r_mag       <= w_x_n;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef MAG_GAIN_COMP_EN
        SCALE: begin
          r_mag       <= w_prod[W2+15:16];
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_x     <= w_x0;
              r_y     <= w_y0;
              r_cnt   <= '0;
              r_state <= ROTATE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_mag_cordic.sv
// Scoreboard bench for fft_mag_cordic: directed vectors with hand values, backpressure,
// mid-operation reset, random back-to-back traffic, and ITER=4/16 side instances.
module tb_fft_mag_cordic;
  localparam int W  = 16;
  localparam int W2 = W + 2;
  localparam int IT = 12;
`ifdef MAG_GAIN_COMP_EN
  localparam int FEAT = 1;
`else
  localparam int FEAT = 0;
`endif

  typedef struct {
    logic [W2-1:0] exact;
    int            approx;
    int            tol;
    int            id;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_re = '0;
  logic [W-1:0]  in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W2-1:0] out_mag;

  logic          a_iv [2];
  logic          a_ir [2];
  logic [W-1:0]  a_re [2];
  logic [W-1:0]  a_im [2];
  logic          a_ov [2];
  logic          a_or [2];
  logic [W2-1:0] a_mag[2];

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  bit   rnd_run = 1'b0;

  always #5 clk = ~clk;

  fft_mag_cordic #(.WIDTH(W), .ITER(IT)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag)
  );

  fft_mag_cordic #(.WIDTH(W), .ITER(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv[0]), .in_ready(a_ir[0]),
    .in_re(a_re[0]), .in_im(a_im[0]), .out_valid(a_ov[0]), .out_ready(a_or[0]),
    .out_mag(a_mag[0])
  );

  fft_mag_cordic #(.WIDTH(W), .ITER(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv[1]), .in_ready(a_ir[1]),
    .in_re(a_re[1]), .in_im(a_im[1]), .out_valid(a_ov[1]), .out_ready(a_or[1]),
    .out_mag(a_mag[1])
  );

  // Golden vectoring CORDIC, bit-exact truncating arithmetic
  function automatic logic [W2-1:0] model(input logic [W-1:0] re, input logic [W-1:0] im,
                                          input int iter);
    logic        [W-1:0]  ar, ai;
    logic        [W2-1:0] x, xs;
    logic signed [W2-1:0] y, ys;
    logic        [W2+15:0] p;
    ar = re[W-1] ? (~re + 16'd1) : re;
    ai = im[W-1] ? (~im + 16'd1) : im;
    x  = {2'b00, ar};
    y  = $signed({2'b00, ai});
    for (int i = 0; i < iter; i++) begin
      xs = x >> i;
      ys = y >>> i;
      if (!y[W2-1]) begin
        x = x + $unsigned(ys);
        y = y - $signed(xs);
      end else begin
        x = x - $unsigned(ys);
        y = y + $signed(xs);
      end
    end
    if (FEAT != 0) begin
      p = {16'b0, x} * 34'd39797;
      x = p[W2+15:16];
    end
    return x;
  endfunction

  function automatic real gain(input int iter);
    real g;
    g = 1.0;
    for (int i = 0; i < iter; i++) g = g * $sqrt(1.0 + (2.0 ** (-2.0 * i)));
    return g;
  endfunction

  // Output monitor: pops one expectation per output handshake
  initial begin : monitor
    exp_t e;
    int   d;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_out++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got mag=%0d, expected no output", out_mag);
        end else begin
          e = q.pop_front();
          if (out_mag !== e.exact) begin
            errors++;
            $display("FAIL exact_mag id=%0d: got %0d, expected %0d", e.id, out_mag, e.exact);
          end
          if (e.tol >= 0) begin
            checks++;
            d = int'(out_mag) - e.approx;
            if (d < -e.tol || d > e.tol) begin
              errors++;
              $display("FAIL approx_mag id=%0d: got %0d, expected %0d +/- %0d",
                       e.id, out_mag, e.approx, e.tol);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im,
                      input int approx, input int tol, input int id);
    exp_t e;
    int   n;
    in_re    = re;
    in_im    = im;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 400);
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout id=%0d: in_ready=%0b after %0d cycles, expected 1", id,
               in_ready, n);
    end else begin
      e.exact  = model(re, im, IT);
      e.approx = approx;
      e.tol    = tol;
      e.id     = id;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Cycles counted from the accept cycle (cycle 1) to the first cycle showing out_valid
  task automatic check_latency(input int id);
    int edges;
    edges = 0;
    forever begin
      @(negedge clk);
      if (out_valid || edges >= 100) break;
      @(posedge clk);
      edges++;
    end
    checks++;
    if (!out_valid || edges + 1 != IT + 1 + FEAT) begin
      errors++;
      $display("FAIL latency id=%0d: got %0d cycles (valid=%0b), expected %0d", id, edges + 1,
               out_valid, IT + 1 + FEAT);
    end
  endtask

  task automatic wait_drain(input int id);
    int n;
    n = 0;
    while (q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain id=%0d: %0d outputs outstanding, expected 0", id, q.size());
    end
  endtask

  task automatic aux(input int k, input logic [W-1:0] re, input logic [W-1:0] im);
    int            n, iter;
    logic [W2-1:0] ex;
    real           az, rf, bnd, g, r_re, r_im;
    iter     = (k == 0) ? 4 : 16;
    a_re[k]  = re;
    a_im[k]  = im;
    a_iv[k]  = 1'b1;
    @(posedge clk);
    #1;
    a_iv[k] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ov[k] && n < 100);
    ex = model(re, im, iter);
    checks++;
    if (!a_ov[k] || a_mag[k] !== ex) begin
      errors++;
      $display("FAIL aux_exact iter=%0d re=%0d im=%0d: got %0d (valid=%0b), expected %0d", iter,
               $signed(re), $signed(im), a_mag[k], a_ov[k], ex);
    end
    r_re = $itor($signed(re));
    r_im = $itor($signed(im));
    az   = $sqrt(r_re * r_re + r_im * r_im);
    g    = (FEAT != 0) ? 1.0 : gain(iter);
    rf   = (FEAT != 0) ? az * gain(iter) * 39797.0 / 65536.0 : az * gain(iter);
    bnd  = ((2.0 ** (1.0 - iter)) * az + 3.0 + iter) * g;
    checks++;
    if ($itor(a_mag[k]) - rf > bnd || rf - $itor(a_mag[k]) > bnd) begin
      errors++;
      $display("FAIL aux_accuracy iter=%0d: got %0d, expected %0f +/- %0f", iter, a_mag[k], rf,
               bnd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : rnd_ready
    forever begin
      @(posedge clk);
      #1;
      if (rnd_run) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : stim
    logic [W2-1:0] held;
    int            base;
    for (int k = 0; k < 2; k++) begin
      a_iv[k] = 1'b0; a_re[k] = '0; a_im[k] = '0; a_or[k] = 1'b1;
    end

    // Reset state, observed while reset is still asserted
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_mag !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%0b mag=%0d in_ready=%0b, expected 0 0 1", out_valid,
               out_mag, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed magnitudes
    send(16'd3000, 16'd4000, FEAT ? 5000 : 8234, FEAT ? 5 : 8, 1);
    in_valid = 1'b0;
    check_latency(1);
    wait_drain(1);
    send(16'h8000, 16'd0, FEAT ? 32768 : 53961, FEAT ? 5 : 8, 2);
    in_valid = 1'b0;
    wait_drain(2);
    send(16'd0, 16'h8000, FEAT ? 32768 : 53961, FEAT ? 5 : 8, 3);
    in_valid = 1'b0;
    wait_drain(3);
    send(16'h8000, 16'h8000, FEAT ? 46341 : 76312, FEAT ? 7 : 10, 4);
    in_valid = 1'b0;
    wait_drain(4);
    send(16'd0, 16'd0, 0, 0, 5);
    in_valid = 1'b0;
    check_latency(5);
    wait_drain(5);

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send(16'hF830, 16'd1500, FEAT ? 2500 : 4117, FEAT ? 5 : 8, 6);
    in_re = 16'd7; in_im = 16'd9;
    check_latency(6);
    held = out_mag;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_mag !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure cyc=%0d: mag=%0d in_ready=%0b valid=%0b, expected %0d 0 1",
                 c, out_mag, in_ready, out_valid, held);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'd1000, 16'd0, FEAT ? 1000 : 1647, FEAT ? 4 : 8, 7);
    in_valid = 1'b0;
    wait_drain(7);

    // Reset during ROTATE iteration 5 discards the in-flight sample
    send(16'd1234, 16'hFDC9, -1, -1, 8);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_mag !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%0b mag=%0d in_ready=%0b, expected 0 0 1", out_valid,
               out_mag, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd3000, 16'd4000, FEAT ? 5000 : 8234, FEAT ? 5 : 8, 9);
    in_valid = 1'b0;
    wait_drain(9);

    // 100 random samples, back-to-back with random output stalls
    base    = n_out;
    rnd_run = 1'b1;
    for (int s = 0; s < 100; s++) send(16'($urandom), 16'($urandom), -1, -1, 100 + s);
    in_valid = 1'b0;
    wait_drain(200);
    rnd_run = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    checks++;
    if (n_out - base != 100) begin
      errors++;
      $display("FAIL random_count: got %0d outputs, expected 100", n_out - base);
    end

    // ITER=4 and ITER=16 instances
    aux(0, 16'd3000, 16'd4000);
    aux(1, 16'h8000, 16'h8000);
    for (int s = 0; s < 20; s++) begin
      aux(0, 16'($urandom), 16'($urandom));
      aux(1, 16'($urandom), 16'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
